// File: rtl/pll_chk_pkg.sv
// -----------------------------------------------------------------------------
// pll_chk_pkg
// Shared types for the PLL frequency checker.
//   state_e : checker FSM states (idle, post-lock settle, gate window, evaluate)
// -----------------------------------------------------------------------------
package pll_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_EVAL    = 2'd3
   } state_e;

endpackage : pll_chk_pkg

// File: rtl/pll_freq_checker_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops reset to 0
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule : sync2

// File: rtl/pll_freq_checker.sv
// -----------------------------------------------------------------------------
// pll_freq_checker
// Counts edges of a PLL-derived toggle signal over a fixed gate window of the
// reference clock and reports whether the rate is within tolerance.
// Ports:
//   clk        : reference clock, all logic on its rising edge
//   rst_n      : asynchronous active-low reset
//   enable     : synchronous enable, low forces the checker idle
//   locked     : PLL lock (asynchronous, synchronized here)
//   toggle_in  : PLL-domain toggle (asynchronous, synchronized here)
//   meas_count : edge count of the last completed window
//   meas_valid : one-cycle pulse when a new result is presented
//   pass/fail  : last result inside / outside EXPECTED +/- TOL
//   good       : PASS_NEED consecutive passing windows since last disqualifier
// -----------------------------------------------------------------------------
module pll_freq_checker
   import pll_chk_pkg::*;
#(
   parameter int WINDOW    = 1000,
   parameter int CNT_W     = 16,
   parameter int EXPECTED  = 100,
   parameter int TOL       = 2,
   parameter int SETTLE    = 256,
   parameter int PASS_NEED = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             locked,
   input  logic             toggle_in,
   output logic [CNT_W-1:0] meas_count,
   output logic             meas_valid,
   output logic             pass,
   output logic             fail,
   output logic             good
);

   localparam int WIN_W = $clog2(WINDOW + 1);
   localparam int SET_W = $clog2(SETTLE + 1);
   localparam int STK_W = $clog2(PASS_NEED + 1);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Tolerance bounds folded into the CNT_W+1 signed comparison range. A
   // negative lower bound acts as zero; a lower bound above the largest
   // representable count can never pass.
   localparam int MAXC  = (2 ** CNT_W) - 1;
   localparam int LO_I  = (EXPECTED - TOL < 0) ? 0 : EXPECTED - TOL;
   localparam int HI_I  = EXPECTED + TOL;
   localparam bit LO_OK = (LO_I <= MAXC);
   localparam logic signed [CNT_W:0] LO_S = (CNT_W+1)'(LO_OK ? LO_I : 0);
   localparam logic signed [CNT_W:0] HI_S =
      (CNT_W+1)'((HI_I > MAXC) ? MAXC : ((HI_I < 0) ? -1 : HI_I));

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + 1'b1;
   endfunction

   function automatic logic in_tol(input logic [CNT_W-1:0] c);
      logic signed [CNT_W:0] cs;
      cs = $signed({1'b0, c});
      return LO_OK && (cs >= LO_S) && (cs <= HI_S);
   endfunction

   // Input synchronization and toggle edge detect
   logic locked_s;
   logic tog_s;
   logic tog_prev_q;
   logic edge_det;

   sync2 u_sync_locked (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (locked),
      .q     (locked_s)
   );

   sync2 u_sync_toggle (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (toggle_in),
      .q     (tog_s)
   );

   // Both polarities of transition count as one edge.
   assign edge_det = tog_s ^ tog_prev_q;

   // Control state and result registers
   state_e             state_q,      state_d;
   logic [SET_W-1:0]   settle_q,     settle_d;
   logic [WIN_W-1:0]   win_q,        win_d;
   logic [CNT_W-1:0]   edge_cnt_q,   edge_cnt_d;
   logic [STK_W-1:0]   streak_q,     streak_d;
   logic               good_q,       good_d;
   logic [CNT_W-1:0]   meas_count_q, meas_count_d;
   logic               meas_valid_q, meas_valid_d;
   logic               pass_q,       pass_d;
   logic               fail_q,       fail_d;

   always_comb begin
      state_d      = state_q;
      settle_d     = settle_q;
      win_d        = win_q;
      edge_cnt_d   = edge_cnt_q;
      streak_d     = streak_q;
      good_d       = good_q;
      meas_count_d = meas_count_q;
      meas_valid_d = 1'b0;
      pass_d       = pass_q;
      fail_d       = fail_q;

      // Losing enable or lock anywhere outside idle abandons the window in
      // flight; the previous result stays on the outputs.
      if ((state_q != ST_IDLE) && !(enable && locked_s)) begin
         state_d  = ST_IDLE;
         streak_d = '0;
         good_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (enable && locked_s) begin
                  state_d  = ST_SETTLE;
                  settle_d = '0;
               end
            end

            ST_SETTLE: begin
               if (settle_q == SET_W'(SETTLE - 1)) begin
                  state_d    = ST_MEASURE;
                  win_d      = '0;
                  edge_cnt_d = '0;
               end else begin
                  settle_d = settle_q + 1'b1;
               end
            end

            ST_MEASURE: begin
               // An edge seen on the final gate cycle still belongs here.
               if (edge_det) begin
                  edge_cnt_d = sat_inc(edge_cnt_q);
               end
               if (win_q == WIN_W'(WINDOW - 1)) begin
                  state_d = ST_EVAL;
               end else begin
                  win_d = win_q + 1'b1;
               end
            end

            ST_EVAL: begin
               meas_valid_d = 1'b1;
               meas_count_d = edge_cnt_q;
               pass_d       = in_tol(edge_cnt_q);
               fail_d       = !pass_d;
               if (pass_d) begin
                  if (streak_q != STK_W'(PASS_NEED)) begin
                     streak_d = streak_q + 1'b1;
                  end
                  good_d = (streak_d == STK_W'(PASS_NEED));
               end else begin
                  streak_d = '0;
                  good_d   = 1'b0;
               end
               // Back-to-back windows: the gate restarts immediately.
               win_d      = '0;
               edge_cnt_d = '0;
               state_d    = ST_MEASURE;
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tog_prev_q   <= 1'b0;
         state_q      <= ST_IDLE;
         settle_q     <= '0;
         win_q        <= '0;
         edge_cnt_q   <= '0;
         streak_q     <= '0;
         good_q       <= 1'b0;
         meas_count_q <= '0;
         meas_valid_q <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         tog_prev_q   <= tog_s;
         state_q      <= state_d;
         settle_q     <= settle_d;
         win_q        <= win_d;
         edge_cnt_q   <= edge_cnt_d;
         streak_q     <= streak_d;
         good_q       <= good_d;
         meas_count_q <= meas_count_d;
         meas_valid_q <= meas_valid_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
      end
   end

   assign meas_count = meas_count_q;
   assign meas_valid = meas_valid_q;
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign good       = good_q;

endmodule : pll_freq_checker
